arc4_ctrl: RTL and testbench
============================

ARC4_CTRL -- requirements
Module: arc4_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16'hFFFF, the maximum cycles a child phase may stay busy before abort.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit, a start request, honoured only while rdy=1.
REQ-005 The block SHALL have port rdy, output, 1 bit, which is 1 when idle and able to accept en.
REQ-006 The block SHALL have port err, output, 1 bit, a sticky timeout flag.
REQ-007 In REQ-008..012, x stands for each of the children init, ksa and prga (key-scheduling and keystream generation); each child has the same five ports.
REQ-008 The block SHALL have port x_en, output, 1 bit, a single-cycle start pulse to child x.
REQ-009 The block SHALL have port x_rdy, input, 1 bit, child x idle/ready.
REQ-010 The block SHALL have port x_addr, input, 8 bits, the S-memory address from child x.
REQ-011 The block SHALL have port x_wrdata, input, 8 bits, the S-memory write data from child x.
REQ-012 The block SHALL have port x_wren, input, 1 bit, the S-memory write enable from child x.
REQ-013 The block SHALL have port s_addr, output, 8 bits, the shared S-memory address.
REQ-014 The block SHALL have port s_wrdata, output, 8 bits, the shared S-memory write data.
REQ-015 The block SHALL have port s_wren, output, 1 bit, the shared S-memory write enable.

Function
REQ-016 The FSM SHALL have states IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO and PRGA_WAIT.
REQ-017 In IDLE: rdy=1; when en=1, the FSM SHALL move to INIT_GO and clear err on the same edge.
REQ-018 In rdy=0 states, en SHALL be ignored (no queueing, no restart).
REQ-019 In x_GO: x_en SHALL be 1 exactly in a cycle where x_rdy=1 (registered decision, one pulse); next state x_WAIT; while x_rdy=0 the FSM SHALL remain in x_GO with x_en=0.
REQ-020 The first cycle of x_WAIT SHALL ignore x_rdy (child drops rdy one cycle after en); from the second cycle on, x_rdy=1 SHALL end the phase.
REQ-021 Phase order SHALL be INIT, KSA, PRGA; x_WAIT done goes to the next x_GO; PRGA_WAIT done goes to IDLE.
REQ-022 Minimum latency: en to rdy=1 SHALL be at least 7 cycles plus child busy times; no idle gap beyond the GO cycle between phases.
REQ-023 The memory mux SHALL be combinational on state: in INIT_* states s_addr/s_wrdata/s_wren = init_*, in KSA_* states = ksa_*, in PRGA_* states = prga_*.
REQ-024 In IDLE the mux SHALL drive s_addr=0, s_wrdata=0, s_wren=0.
REQ-025 A non-owning child's x_wren SHALL never reach s_wren.
REQ-026 At most one x_en SHALL be high in any cycle; x_en SHALL never be high in IDLE.
REQ-027 Watchdog: a 16-bit counter SHALL clear on entry to each x_GO, increment every cycle in x_GO/x_WAIT and saturate at TIMEOUT.
REQ-028 On reaching TIMEOUT, the FSM SHALL go to IDLE next edge with err=1; err SHALL stay 1 until the next accepted en or rst.
REQ-029 If x_rdy=1 and TIMEOUT are reached in the same cycle, completion SHALL win (no err).

Reset
REQ-030 When rst=1 at a clock edge, state SHALL become IDLE, err=0, watchdog=0, all x_en=0; from the next cycle rdy=1 and s_wren=0.
REQ-031 rst mid-phase SHALL abort with no further x_en pulse; the child is not reset by this block.
REQ-032 Before the first rst edge, outputs are undefined; the bench SHALL reset first.

Verification
REQ-033 Normal run: stub children drop rdy 1 cycle after en and are busy 256/768/10 cycles; pulse en -> init_en, ksa_en and prga_en each pulse once in order, rdy returns 1, err=0.
REQ-034 Mux: init_wren=1 with addr 8'h5A while in INIT_WAIT, ksa_wren=1 concurrently -> s_addr=8'h5A, s_wren follows init_wren only; in IDLE s_wren=0.
REQ-035 Gating: ksa_rdy held 0 for 20 cycles at KSA_GO -> ksa_en stays 0, then pulses once in the cycle after ksa_rdy rises.
REQ-036 Timeout: with TIMEOUT=16'd50 and prga_rdy stuck 0 -> IDLE with err=1 after 50 cycles; next en clears err.
REQ-037 Reset mid-KSA (cycle 100 of 768) -> next cycle rdy=1, all x_en=0, s_wren=0; en=1 during busy is ignored (one init_en pulse total).

Source files
------------

// File: rtl/arc4_ctrl.sv
// arc4_ctrl: top-level sequencer for the ARC4 engine. Runs the init, ksa and
// prga children in order, owns the shared S-memory port on their behalf and
// aborts any phase that stays busy longer than TIMEOUT cycles.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | rdy=1, waiting for en; S-memory port driven to zero
// INIT_GO     | waiting for init_rdy, then issue one init_en pulse
// INIT_WAIT   | init child busy; first cycle ignores init_rdy
// KSA_GO      | waiting for ksa_rdy, then issue one ksa_en pulse
// KSA_WAIT    | ksa child busy; first cycle ignores ksa_rdy
// PRGA_GO     | waiting for prga_rdy, then issue one prga_en pulse
// PRGA_WAIT   | prga child busy; first cycle ignores prga_rdy
module arc4_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic       err,

  output logic       init_en,
  input  logic       init_rdy,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wrdata,
  input  logic       init_wren,

  output logic       ksa_en,
  input  logic       ksa_rdy,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_wrdata,
  input  logic       ksa_wren,

  output logic       prga_en,
  input  logic       prga_rdy,
  input  logic [7:0] prga_addr,
  input  logic [7:0] prga_wrdata,
  input  logic       prga_wren,

  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_GO   = 3'd1,
    INIT_WAIT = 3'd2,
    KSA_GO    = 3'd3,
    KSA_WAIT  = 3'd4,
    PRGA_GO   = 3'd5,
    PRGA_WAIT = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_wd;
  logic        r_err;
  logic        r_wait_first;
  logic        r_init_en;
  logic        r_ksa_en;
  logic        r_prga_en;

  logic        w_timeout;
  logic        w_init_go;
  logic        w_ksa_go;
  logic        w_prga_go;
  logic        w_set_err;
  logic        w_clr_err;
  logic        w_enter_go;
  logic        w_in_phase;

  // The watchdog has hit its limit; completion in the same cycle still wins.
  assign w_timeout  = (r_wd == TIMEOUT);
  assign w_in_phase = (r_state != IDLE);

  assign rdy     = (r_state == IDLE);
  assign err     = r_err;
  assign init_en = r_init_en;
  assign ksa_en  = r_ksa_en;
  assign prga_en = r_prga_en;

  // Next-state decision: GO waits for the child to be ready, WAIT waits for it
  // to come back ready (skipping the first cycle, where rdy is still stale).
  always_comb begin
    w_next    = r_state;
    w_init_go = 1'b0;
    w_ksa_go  = 1'b0;
    w_prga_go = 1'b0;
    w_set_err = 1'b0;
    w_clr_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_next    = INIT_GO;
          w_clr_err = 1'b1;
        end
      end
      INIT_GO: begin
        if (init_rdy) begin
          w_next    = INIT_WAIT;
          w_init_go = 1'b1;
        end else if (w_timeout) begin
          w_next    = IDLE;
          w_set_err = 1'b1;
        end
      end
      INIT_WAIT: begin
        if (!r_wait_first && init_rdy) begin
          w_next = KSA_GO;
        end else if (w_timeout) begin
          w_next    = IDLE;
          w_set_err = 1'b1;
        end
      end
      KSA_GO: begin
        if (ksa_rdy) begin
          w_next   = KSA_WAIT;
          w_ksa_go = 1'b1;
        end else if (w_timeout) begin
          w_next    = IDLE;
          w_set_err = 1'b1;
        end
      end
      KSA_WAIT: begin
        if (!r_wait_first && ksa_rdy) begin
          w_next = PRGA_GO;
        end else if (w_timeout) begin
          w_next    = IDLE;
          w_set_err = 1'b1;
        end
      end
      PRGA_GO: begin
        if (prga_rdy) begin
          w_next    = PRGA_WAIT;
          w_prga_go = 1'b1;
        end else if (w_timeout) begin
          w_next    = IDLE;
          w_set_err = 1'b1;
        end
      end
      PRGA_WAIT: begin
        if (!r_wait_first && prga_rdy) begin
          w_next = IDLE;
        end else if (w_timeout) begin
          w_next    = IDLE;
          w_set_err = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Detect the edge on which a new GO state is entered (restarts the watchdog).
  always_comb begin
    w_enter_go = 1'b0;
    if ((w_next == INIT_GO) || (w_next == KSA_GO) || (w_next == PRGA_GO)) begin
      w_enter_go = (w_next != r_state);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Watchdog: restarts on each GO entry, counts through GO/WAIT, saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd <= 16'd0;
    end else if (w_enter_go || (w_next == IDLE)) begin
      r_wd <= 16'd0;
    end else if (w_in_phase && !w_timeout) begin
      r_wd <= r_wd + 16'd1;
    end
  end

  // Sticky error flag, cleared only by an accepted start or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_clr_err) begin
      r_err <= 1'b0;
    end else if (w_set_err) begin
      r_err <= 1'b1;
    end
  end

  // Registered one-cycle start pulses and the first-WAIT-cycle marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_en    <= 1'b0;
      r_ksa_en     <= 1'b0;
      r_prga_en    <= 1'b0;
      r_wait_first <= 1'b0;
    end else begin
      r_init_en    <= w_init_go;
      r_ksa_en     <= w_ksa_go;
      r_prga_en    <= w_prga_go;
      r_wait_first <= w_init_go | w_ksa_go | w_prga_go;
    end
  end

  // Shared S-memory mux: only the child owning the current phase gets through.
  always_comb begin
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    case (r_state)
      INIT_GO, INIT_WAIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      KSA_GO, KSA_WAIT: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      PRGA_GO, PRGA_WAIT: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arc4_ctrl.sv
// tb_arc4_ctrl: drives arc4_ctrl with behavioural child stubs and randomized
// busy lengths and memory traffic; a second instance with a short TIMEOUT
// exercises the watchdog abort.
`timescale 1ns/1ps
module tb_arc4_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       rdy, err;
  logic       init_en, ksa_en, prga_en;
  logic       init_rdy, ksa_rdy, prga_rdy;
  logic [7:0] s_addr, s_wrdata;
  logic       s_wren;

  // Child stubs: index 0=init, 1=ksa, 2=prga.
  logic [2:0] c_rdy_r = 3'b111;
  int         c_cnt [3];
  int         c_len [3];
  logic [7:0] c_addr [3];
  logic [7:0] c_wdat [3];
  logic [2:0] c_wren = 3'b000;
  logic [2:0] c_en;
  logic       ksa_hold = 1'b0;

  assign c_en     = {prga_en, ksa_en, init_en};
  assign init_rdy = c_rdy_r[0];
  assign ksa_rdy  = c_rdy_r[1] & ~ksa_hold;
  assign prga_rdy = c_rdy_r[2];

  // Second instance: init/ksa always ready, prga stuck busy.
  logic       en2 = 1'b0;
  logic       rdy2, err2, init_en2, ksa_en2, prga_en2;
  logic [7:0] s2_addr, s2_wrdata;
  logic       s2_wren;

  arc4_ctrl u_dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .err(err),
    .init_en(init_en), .init_rdy(init_rdy), .init_addr(c_addr[0]),
    .init_wrdata(c_wdat[0]), .init_wren(c_wren[0]),
    .ksa_en(ksa_en), .ksa_rdy(ksa_rdy), .ksa_addr(c_addr[1]),
    .ksa_wrdata(c_wdat[1]), .ksa_wren(c_wren[1]),
    .prga_en(prga_en), .prga_rdy(prga_rdy), .prga_addr(c_addr[2]),
    .prga_wrdata(c_wdat[2]), .prga_wren(c_wren[2]),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  arc4_ctrl #(.TIMEOUT(16'd50)) u_dut_to (
    .clk(clk), .rst(rst), .en(en2), .rdy(rdy2), .err(err2),
    .init_en(init_en2), .init_rdy(1'b1), .init_addr(8'd0),
    .init_wrdata(8'd0), .init_wren(1'b0),
    .ksa_en(ksa_en2), .ksa_rdy(1'b1), .ksa_addr(8'd0),
    .ksa_wrdata(8'd0), .ksa_wren(1'b0),
    .prga_en(prga_en2), .prga_rdy(1'b0), .prga_addr(8'd0),
    .prga_wrdata(8'd0), .prga_wren(1'b0),
    .s_addr(s2_addr), .s_wrdata(s2_wrdata), .s_wren(s2_wren)
  );

  // Stub children: drop rdy the cycle after their en, stay busy c_len cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (c_en[i]) begin
        c_rdy_r[i] <= 1'b0;
        c_cnt[i]   <= c_len[i] - 1;
      end else if (!c_rdy_r[i]) begin
        if (c_cnt[i] == 0) c_rdy_r[i] <= 1'b1;
        else c_cnt[i] <= c_cnt[i] - 1;
      end
      c_addr[i] <= 8'($urandom);
      c_wdat[i] <= 8'($urandom);
      c_wren[i] <= 1'($urandom);
    end
  end

  // Scoreboard state.
  int    sb [$];
  string q_nm [$];
  int    q_act [$];
  int    q_exp [$];
  int    n_chk = 0;
  int    n_err = 0;
  int    owner = -1;
  logic  started = 1'b0;

  task automatic do_check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: drains queued checks, matches start pulses against the expected
  // order and checks the memory mux against the phase owner.
  always @(negedge clk) begin
    int k, k2, id;
    while (q_nm.size() != 0) begin
      do_check(q_nm.pop_front(), q_act.pop_front(), q_exp.pop_front());
    end
    if (started) begin
      k  = int'(init_en) + int'(ksa_en) + int'(prga_en);
      k2 = int'(init_en2) + int'(ksa_en2) + int'(prga_en2);
      do_check("en_onehot", int'(k <= 1), 1);
      do_check("to_en_onehot", int'(k2 <= 1), 1);
      do_check("to_mux_zero", int'({s2_addr, s2_wrdata, s2_wren}), 0);
      if (rdy) begin
        do_check("en_in_idle", k, 0);
        do_check("mux_idle", int'({s_addr, s_wrdata, s_wren}), 0);
      end
      if (k == 1) begin
        id = init_en ? 0 : (ksa_en ? 1 : 2);
        owner = id;
        if (sb.size() == 0) do_check("en_unexpected", id, -1);
        else do_check("en_order", id, sb.pop_front());
      end
      if (!rdy && owner >= 0 && (c_en[owner] || !c_rdy_r[owner])) begin
        do_check("mux_owner", int'({s_addr, s_wrdata, s_wren}),
                 int'({c_addr[owner], c_wdat[owner], c_wren[owner]}));
      end
    end
    if (rst) owner = -1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_eq(input string nm, input int act, input int exp);
    q_nm.push_back(nm);
    q_act.push_back(act);
    q_exp.push_back(exp);
  endtask

  task automatic wait_stubs_idle();
    for (int i = 0; i < 3000; i++) begin
      if (c_rdy_r == 3'b111) break;
      step();
    end
    expect_eq("stubs_idle", int'(c_rdy_r), 7);
  endtask

  task automatic start_run();
    expect_eq("start_rdy", int'(rdy), 1);
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(2);
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  // Waits for rdy after an accepted start; returns edges taken.
  task automatic finish_run(input bit poke_en, output int n, output bit done);
    n = 0;
    done = 1'b0;
    while (!done && n < 5000) begin
      step();
      n++;
      if (rdy) begin
        done = 1'b1;
        en = 1'b0;
      end else begin
        en = (poke_en && n == 3);
      end
    end
    en = 1'b0;
    expect_eq("run_done", int'(done), 1);
    expect_eq("run_err", int'(err), 0);
    expect_eq("sb_empty", sb.size(), 0);
  endtask

  task automatic full_run(input bit poke_en);
    int  n;
    bit  done;
    int  sum;
    wait_stubs_idle();
    sum = c_len[0] + c_len[1] + c_len[2];
    start_run();
    finish_run(poke_en, n, done);
    // GO cycle + en cycle + busy + one cycle to see rdy, per phase.
    expect_eq("latency", n, sum + 9);
  endtask

  initial begin
    int  n;
    bit  done;
    c_len[0] = 256; c_len[1] = 768; c_len[2] = 10;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    started = 1'b1;
    expect_eq("rst_rdy", int'(rdy), 1);
    expect_eq("rst_err", int'(err), 0);
    expect_eq("rst_en", int'(c_en), 0);
    expect_eq("rst_swren", int'(s_wren), 0);
    expect_eq("rst_saddr", int'(s_addr), 0);
    expect_eq("rst_rdy2", int'(rdy2), 1);
    expect_eq("rst_err2", int'(err2), 0);

    // Normal run with the reference busy times.
    full_run(1'b0);

    // Gating: ksa_rdy held low for 20 cycles in KSA_GO.
    c_len[0] = 20; c_len[1] = 30; c_len[2] = 5;
    wait_stubs_idle();
    ksa_hold = 1'b1;
    start_run();
    repeat (3 + c_len[0]) step();
    for (int i = 0; i < 20; i++) begin
      expect_eq("gate_hold", int'(ksa_en), 0);
      step();
    end
    ksa_hold = 1'b0;
    expect_eq("gate_rise", int'(ksa_en), 0);
    step();
    expect_eq("gate_pulse", int'(ksa_en), 1);
    step();
    expect_eq("gate_after", int'(ksa_en), 0);
    finish_run(1'b0, n, done);

    // Randomized runs, some with en poked while busy.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) c_len[i] = int'($urandom_range(40, 1));
      full_run(r[0]);
    end

    // Watchdog abort on the TIMEOUT=50 instance.
    expect_eq("to_start_rdy", int'(rdy2), 1);
    en2 = 1'b1;
    step();
    en2 = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      step();
      n++;
      if (n == 10) expect_eq("to_err_early", int'(err2), 0);
      if (rdy2) done = 1'b1;
    end
    expect_eq("to_done", int'(done), 1);
    expect_eq("to_window", int'(n >= 56 && n <= 58), 1);
    expect_eq("to_err", int'(err2), 1);
    repeat (3) step();
    expect_eq("to_err_sticky", int'(err2), 1);
    en2 = 1'b1;
    step();
    en2 = 1'b0;
    expect_eq("to_err_clr", int'(err2), 0);
    expect_eq("to_busy", int'(rdy2), 0);

    // Reset in the middle of KSA, with an ignored en during INIT.
    c_len[0] = 256; c_len[1] = 768; c_len[2] = 10;
    wait_stubs_idle();
    start_run();
    n = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      step();
      n++;
      en = (n == 50);
      if (ksa_en) done = 1'b1;
    end
    en = 1'b0;
    expect_eq("ksa_reached", int'(done), 1);
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    expect_eq("mid_rst_rdy", int'(rdy), 1);
    expect_eq("mid_rst_en", int'(c_en), 0);
    expect_eq("mid_rst_swren", int'(s_wren), 0);
    expect_eq("mid_rst_err", int'(err), 0);
    expect_eq("mid_rst_err2", int'(err2), 0);
    repeat (5) step();

    // Recovery after the abort.
    full_run(1'b0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
